// File: rtl/mips_shift_pkg.sv
// rtl/mips_shift_pkg.sv - shared decode constants, types and helpers for the shift execute stage
//
// Contents:
//   FUNCT_*        MIPS R-type funct codes of the six shift instructions
//   shift_dir_e    shift direction (SHIFT_LEFT, SHIFT_RIGHT)
//   s1_payload_t   decoded instruction held in pipeline stage S1
//   bit_reverse()  mirror a 32-bit word (bit 0 <-> bit 31)
package mips_shift_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

  typedef struct packed {
    shift_dir_e  dir;
    logic        arith;
    logic [4:0]  amt;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic        illegal;
  } s1_payload_t;

  function automatic logic [31:0] bit_reverse(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_shift_exec_stage_shift_core.sv
// rtl/mips_shift_exec_stage_shift_core.sv - combinational 32-bit shifter (module shift_core)
//
// Ports:
//   data   [31:0] in   value to shift
//   amt    [4:0]  in   shift amount, 0..31
//   dir           in   SHIFT_LEFT / SHIFT_RIGHT
//   arith         in   sign-fill on right shifts
//   result [31:0] out  shifted value
// Build option: SHIFT_ARITH_EN enables the sign-fill logic; without it every
// shift fills with zero and arith is ignored.
module shift_core
  import mips_shift_pkg::*;
(
  input  logic [31:0] data,
  input  logic [4:0]  amt,
  input  shift_dir_e  dir,
  input  logic        arith,
  output logic [31:0] result
);

  logic [31:0] src;
  logic [31:0] shr;
  logic [31:0] fill_mask;

`ifdef SHIFT_ARITH_EN
  always_comb begin
    // Ones over the vacated upper bits; only used for arithmetic right shifts.
    fill_mask = '0;
    if (arith && (dir == SHIFT_RIGHT) && data[31]) begin
      fill_mask = ~(32'hFFFF_FFFF >> amt);
    end
  end
`else
  logic unused_arith;
  assign unused_arith = arith;
  assign fill_mask    = '0;
`endif

  // A single right shifter serves both directions: a left shift is a right
  // shift of the mirrored word, mirrored back.
  always_comb begin
    src    = (dir == SHIFT_LEFT) ? bit_reverse(data) : data;
    shr    = src >> amt;
    result = (dir == SHIFT_LEFT) ? bit_reverse(shr) : (shr | fill_mask);
  end

endmodule

// File: rtl/mips_shift_exec_stage.sv
// rtl/mips_shift_exec_stage.sv - two-stage execute front end for MIPS32 shift instructions
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake
//   in_funct, in_shamt         instruction fields
//   in_rs, in_rt, in_rd        rs value (variable amount), rt value (data), destination
//   out_valid / out_ready      writeback handshake
//   out_result, out_rd         shifted value and destination
//   out_illegal                funct was not a supported shift (result forced to 0)
// Build option: SHIFT_ARITH_EN enables SRA/SRAV; otherwise they decode as illegal.
module mips_shift_exec_stage
  import mips_shift_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_shamt,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  s1_payload_t dec;
  s1_payload_t s1_d, s1_q;
  logic        s1_valid_d, s1_valid_q;
  logic        s2_valid_d, s2_valid_q;
  logic [31:0] s2_result_d, s2_result_q;
  logic [4:0]  s2_rd_d, s2_rd_q;
  logic        s2_illegal_d, s2_illegal_q;
  logic [31:0] core_result;
  logic        s2_adv, s1_adv;

  // Only rs[4:0] matters as a shift amount.
  logic [26:0] unused_rs;
  assign unused_rs = in_rs[31:5];

  always_comb begin
    dec         = '0;
    dec.rt      = in_rt;
    dec.rd      = in_rd;
    dec.dir     = SHIFT_LEFT;
    dec.arith   = 1'b0;
    dec.amt     = 5'd0;
    dec.illegal = 1'b0;
    case (in_funct)
      FUNCT_SLL:  begin dec.dir = SHIFT_LEFT;  dec.amt = in_shamt;   end
      FUNCT_SRL:  begin dec.dir = SHIFT_RIGHT; dec.amt = in_shamt;   end
      FUNCT_SLLV: begin dec.dir = SHIFT_LEFT;  dec.amt = in_rs[4:0]; end
      FUNCT_SRLV: begin dec.dir = SHIFT_RIGHT; dec.amt = in_rs[4:0]; end
`ifdef SHIFT_ARITH_EN
      FUNCT_SRA:  begin dec.dir = SHIFT_RIGHT; dec.arith = 1'b1; dec.amt = in_shamt;   end
      FUNCT_SRAV: begin dec.dir = SHIFT_RIGHT; dec.arith = 1'b1; dec.amt = in_rs[4:0]; end
`endif
      default:    dec.illegal = 1'b1;
    endcase
  end

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;

  shift_core u_core (
    .data   (s1_q.rt),
    .amt    (s1_q.amt),
    .dir    (s1_q.dir),
    .arith  (s1_q.arith),
    .result (core_result)
  );

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_d         = s1_q;
    s2_valid_d   = s2_valid_q;
    s2_result_d  = s2_result_q;
    s2_rd_d      = s2_rd_q;
    s2_illegal_d = s2_illegal_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d = dec;
      end
    end

    // S2 only moves when it is empty or being drained, which keeps the
    // outputs frozen while writeback stalls.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_adv) begin
        s2_result_d  = s1_q.illegal ? 32'h0 : core_result;
        s2_rd_d      = s1_q.rd;
        s2_illegal_d = s1_q.illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_rd_q      <= '0;
      s2_illegal_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_rd_q      <= s2_rd_d;
      s2_illegal_q <= s2_illegal_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = s2_result_q;
  assign out_rd      = s2_rd_q;
  assign out_illegal = s2_illegal_q;

endmodule
